// File: rtl/icache.sv
// icache: direct-mapped instruction cache sitting between ifetch and memory.
// Ifetch lookups that hit return an instruction one cycle later. A miss raises
// a line-aligned block request to memory and holds it until memory returns the
// block together with the index and tag to write. A flush from the ROB cancels
// any pending answer to ifetch but never invalidates lines.
//
// Optional feature: define ICACHE_STAT_EN to add hit/miss lookup counters.
//
// Ports:
//   clk, rst_in (sync, active-low), rdy_in (0 freezes all state), flush_in
//   ifetch2cache_en / ifetch2cache_PC              lookup request
//   cache2ifetch_rdy / _vld / _ins                 lookup response
//   cache2mem_upd_en / cache2mem_PC                block request to memory
//   mem2cache_upd / _blk / _idx / _tag             block return from memory
//   hit_cnt / miss_cnt (ICACHE_STAT_EN only)       lookup statistics
module icache #(
  parameter  int ADDR_WIDTH   = 32,
  parameter  int INDEX_WIDTH  = 4,
  parameter  int OFFSET_WIDTH = 4,
  localparam int BLOCK_WIDTH  = 8 << OFFSET_WIDTH,
  localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   flush_in,
  input  logic                   ifetch2cache_en,
  input  logic [ADDR_WIDTH-1:0]  ifetch2cache_PC,
  output logic                   cache2ifetch_rdy,
  output logic                   cache2ifetch_vld,
  output logic [31:0]            cache2ifetch_ins,
  output logic                   cache2mem_upd_en,
  output logic [ADDR_WIDTH-1:0]  cache2mem_PC,
  input  logic                   mem2cache_upd,
  input  logic [BLOCK_WIDTH-1:0] mem2cache_blk,
  input  logic [INDEX_WIDTH-1:0] mem2cache_idx,
  input  logic [TAG_WIDTH-1:0]   mem2cache_tag
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0]            hit_cnt,
  output logic [31:0]            miss_cnt
`endif
);

  localparam int LINES      = 1 << INDEX_WIDTH;
  localparam int WORD_SEL_W = OFFSET_WIDTH - 2;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    {{(ADDR_WIDTH-OFFSET_WIDTH){1'b1}}, {OFFSET_WIDTH{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MISS, S_DRAIN} state_t;

  state_t                 state;
  logic [LINES-1:0]       valid;
  logic [TAG_WIDTH-1:0]   tag_arr  [LINES];
  logic [BLOCK_WIDTH-1:0] data_arr [LINES];
  logic [WORD_SEL_W-1:0]  req_word;

  logic [INDEX_WIDTH-1:0] pc_idx;
  logic [TAG_WIDTH-1:0]   pc_tag;
  logic [WORD_SEL_W-1:0]  pc_word;
  logic [BLOCK_WIDTH-1:0] hit_blk;
  logic [31:0]            hit_ins;
  logic [31:0]            refill_ins;
  logic                   hit;
  logic                   lookup;
  logic                   arr_wr;

  always_comb begin
    pc_idx     = ifetch2cache_PC[OFFSET_WIDTH +: INDEX_WIDTH];
    pc_tag     = ifetch2cache_PC[ADDR_WIDTH-1 -: TAG_WIDTH];
    pc_word    = ifetch2cache_PC[OFFSET_WIDTH-1:2];
    hit_blk    = data_arr[pc_idx];
    hit_ins    = hit_blk[32*int'(pc_word) +: 32];
    // Refill answers with the word the missing request asked for, taken
    // straight from the returning block rather than from the array.
    refill_ins = mem2cache_blk[32*int'(req_word) +: 32];
    hit        = valid[pc_idx] && (tag_arr[pc_idx] == pc_tag);
    lookup     = rdy_in && (state == S_IDLE) && ifetch2cache_en && !flush_in;
    // Index/tag come from memory, not from the latched PC.
    arr_wr     = rst_in && rdy_in && mem2cache_upd && (state != S_IDLE);
  end

  assign cache2ifetch_rdy = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (arr_wr) begin
      tag_arr[mem2cache_idx]  <= mem2cache_tag;
      data_arr[mem2cache_idx] <= mem2cache_blk;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state            <= S_IDLE;
      valid            <= '0;
      req_word         <= '0;
      cache2ifetch_vld <= 1'b0;
      cache2ifetch_ins <= '0;
      cache2mem_upd_en <= 1'b0;
      cache2mem_PC     <= '0;
    end else if (rdy_in) begin
      cache2ifetch_vld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ifetch2cache_en && !flush_in) begin
            if (hit) begin
              cache2ifetch_vld <= 1'b1;
              cache2ifetch_ins <= hit_ins;
            end else begin
              req_word         <= pc_word;
              cache2mem_upd_en <= 1'b1;
              cache2mem_PC     <= ifetch2cache_PC & ALIGN_MASK;
              state            <= S_MISS;
            end
          end
        end
        S_MISS: begin
          if (mem2cache_upd) begin
            valid[mem2cache_idx] <= 1'b1;
            cache2mem_upd_en     <= 1'b0;
            state                <= S_IDLE;
            if (!flush_in) begin
              cache2ifetch_vld <= 1'b1;
              cache2ifetch_ins <= refill_ins;
            end
          end else if (flush_in) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Memory cannot abort, so the request stays up until the block lands.
          if (mem2cache_upd) begin
            valid[mem2cache_idx] <= 1'b1;
            cache2mem_upd_en     <= 1'b0;
            state                <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ICACHE_STAT_EN
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (lookup) begin
      if (hit) hit_cnt  <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`else
  logic unused_lookup;
  assign unused_lookup = lookup;
`endif

endmodule

// File: tb/tb_icache.sv
module tb_icache;

  logic         clk;
  logic         rst_in;
  logic         rdy_in;
  logic         flush_in;
  logic         ifetch2cache_en;
  logic [31:0]  ifetch2cache_PC;
  logic         cache2ifetch_rdy;
  logic         cache2ifetch_vld;
  logic [31:0]  cache2ifetch_ins;
  logic         cache2mem_upd_en;
  logic [31:0]  cache2mem_PC;
  logic         mem2cache_upd;
  logic [127:0] mem2cache_blk;
  logic [3:0]   mem2cache_idx;
  logic [23:0]  mem2cache_tag;
`ifdef ICACHE_STAT_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  icache #(.ADDR_WIDTH(32), .INDEX_WIDTH(4), .OFFSET_WIDTH(4)) dut (
    .clk              (clk),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .flush_in         (flush_in),
    .ifetch2cache_en  (ifetch2cache_en),
    .ifetch2cache_PC  (ifetch2cache_PC),
    .cache2ifetch_rdy (cache2ifetch_rdy),
    .cache2ifetch_vld (cache2ifetch_vld),
    .cache2ifetch_ins (cache2ifetch_ins),
    .cache2mem_upd_en (cache2mem_upd_en),
    .cache2mem_PC     (cache2mem_PC),
    .mem2cache_upd    (mem2cache_upd),
    .mem2cache_blk    (mem2cache_blk),
    .mem2cache_idx    (mem2cache_idx),
    .mem2cache_tag    (mem2cache_tag)
`ifdef ICACHE_STAT_EN
    ,
    .hit_cnt          (hit_cnt),
    .miss_cnt         (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         rst;
    logic         flush;
    logic         en;
    logic [31:0]  pc;
    logic         upd;
    logic [127:0] blk;
    logic [3:0]   idx;
    logic [23:0]  tag;
    logic         e_vld;
    logic [31:0]  e_ins;
    logic         e_upd;
    logic [31:0]  e_mpc;
    logic         e_rdy;
  } vec_t;

  function automatic logic [127:0] words4(input logic [31:0] w0, input logic [31:0] w1,
                                          input logic [31:0] w2, input logic [31:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [127:0] seq4(input logic [31:0] base);
    return words4(base, base + 32'd1, base + 32'd2, base + 32'd3);
  endfunction

  function automatic vec_t mk(input logic rst, input logic flush, input logic en,
                              input logic [31:0] pc, input logic upd, input logic [127:0] blk,
                              input logic [3:0] idx, input logic [23:0] tag,
                              input logic e_vld, input logic [31:0] e_ins, input logic e_upd,
                              input logic [31:0] e_mpc, input logic e_rdy);
    vec_t v;
    v.rst = rst; v.flush = flush; v.en = en; v.pc = pc; v.upd = upd;
    v.blk = blk; v.idx = idx; v.tag = tag;
    v.e_vld = e_vld; v.e_ins = e_ins; v.e_upd = e_upd; v.e_mpc = e_mpc; v.e_rdy = e_rdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic flush, input logic en,
                       input logic [31:0] pc, input logic upd, input logic [127:0] blk,
                       input logic [3:0] idx, input logic [23:0] tag);
    rst_in = rst; rdy_in = rdy; flush_in = flush; ifetch2cache_en = en;
    ifetch2cache_PC = pc; mem2cache_upd = upd; mem2cache_blk = blk;
    mem2cache_idx = idx; mem2cache_tag = tag;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic vld, input logic [31:0] ins,
                            input logic upd, input logic [31:0] mpc, input logic rdy);
    chk({tag, ".vld"}, {31'd0, cache2ifetch_vld}, {31'd0, vld});
    chk({tag, ".ins"}, cache2ifetch_ins, ins);
    chk({tag, ".upd_en"}, {31'd0, cache2mem_upd_en}, {31'd0, upd});
    chk({tag, ".mem_pc"}, cache2mem_PC, mpc);
    chk({tag, ".rdy"}, {31'd0, cache2ifetch_rdy}, {31'd0, rdy});
  endtask

  localparam logic [31:0] A0 = 32'h0000_0093;
  localparam logic [31:0] A1 = 32'h0010_0113;
  localparam logic [31:0] A2 = 32'h0020_0193;
  localparam logic [31:0] A3 = 32'h0030_0213;

  vec_t tbl[$];
  logic [127:0] blk_a, blk_b, blk_c, blk_d, blk_e, blk_f;

  initial begin
    blk_a = words4(A0, A1, A2, A3);
    blk_b = seq4(32'hB000_0000);
    blk_c = seq4(32'hC000_0000);
    blk_d = seq4(32'hD000_0000);
    blk_e = seq4(32'hE000_0000);
    blk_f = seq4(32'hF000_0000);

    //                rst fl en pc            upd blk    idx    tag        vld ins          upd mpc           rdy
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, '0,    4'h0, 24'h0,     0, 32'h0,        0, 32'h0,        1)); // reset
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, '0,    4'h0, 24'h0,     0, 32'h0,        0, 32'h0,        1));
    tbl.push_back(mk(1, 0, 1, 32'h0,        0, '0,    4'h0, 24'h0,     0, 32'h0,        1, 32'h0,        0)); // cold miss
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, '0,    4'h0, 24'h0,     0, 32'h0,        1, 32'h0,        0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, blk_a, 4'h0, 24'h0,     1, A0,           0, 32'h0,        1)); // refill
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, '0,    4'h0, 24'h0,     0, A0,           0, 32'h0,        1)); // ins held
    tbl.push_back(mk(1, 0, 1, 32'h4,        0, '0,    4'h0, 24'h0,     1, A1,           0, 32'h0,        1)); // hit word1
    tbl.push_back(mk(1, 0, 1, 32'hC,        0, '0,    4'h0, 24'h0,     1, A3,           0, 32'h0,        1)); // back-to-back hit
    tbl.push_back(mk(1, 0, 1, 32'hE,        0, '0,    4'h0, 24'h0,     1, A3,           0, 32'h0,        1)); // PC[1:0] ignored
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, blk_b, 4'h0, 24'h1,     0, A3,           0, 32'h0,        1)); // stray upd in IDLE
    tbl.push_back(mk(1, 0, 1, 32'h100,      0, '0,    4'h0, 24'h0,     0, A3,           1, 32'h100,      0)); // tag 1 misses
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, blk_b, 4'h0, 24'h1,     1, 32'hB000_0000, 0, 32'h100,    1));
    tbl.push_back(mk(1, 0, 1, 32'h108,      0, '0,    4'h0, 24'h0,     1, 32'hB000_0002, 0, 32'h100,    1));
    tbl.push_back(mk(1, 0, 1, 32'h0,        0, '0,    4'h0, 24'h0,     0, 32'hB000_0002, 1, 32'h0,      0)); // evicted
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, blk_a, 4'h0, 24'h0,     1, A0,           0, 32'h0,        1));
    tbl.push_back(mk(1, 1, 1, 32'h4,        0, '0,    4'h0, 24'h0,     0, A0,           0, 32'h0,        1)); // flush in IDLE
    tbl.push_back(mk(1, 0, 1, 32'h44,       0, '0,    4'h0, 24'h0,     0, A0,           1, 32'h40,       0)); // aligned request
    tbl.push_back(mk(1, 1, 0, 32'h0,        0, '0,    4'h0, 24'h0,     0, A0,           1, 32'h40,       0)); // flush -> DRAIN
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, '0,    4'h0, 24'h0,     0, A0,           1, 32'h40,       0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, blk_c, 4'h4, 24'h0,     0, A0,           0, 32'h40,       1)); // drained, no vld
    tbl.push_back(mk(1, 0, 1, 32'h48,       0, '0,    4'h0, 24'h0,     1, 32'hC000_0002, 0, 32'h40,     1)); // now hits
    tbl.push_back(mk(1, 0, 1, 32'h84,       0, '0,    4'h0, 24'h0,     0, 32'hC000_0002, 1, 32'h80,     0));
    tbl.push_back(mk(1, 1, 0, 32'h0,        1, blk_d, 4'h8, 24'h0,     0, 32'hC000_0002, 0, 32'h80,     1)); // flush+upd
    tbl.push_back(mk(1, 0, 1, 32'h80,       0, '0,    4'h0, 24'h0,     1, 32'hD000_0000, 0, 32'h80,     1));
    tbl.push_back(mk(1, 0, 1, 32'hC4,       0, '0,    4'h0, 24'h0,     0, 32'hD000_0000, 1, 32'hC0,     0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, blk_e, 4'hC, 24'h0,     1, 32'hE000_0001, 0, 32'hC0,     1)); // refill word1

    drive(0, 1, 0, 0, 32'h0, 0, '0, 4'h0, 24'h0);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, 1'b1, tbl[i].flush, tbl[i].en, tbl[i].pc, tbl[i].upd,
            tbl[i].blk, tbl[i].idx, tbl[i].tag);
      step();
      expect_out($sformatf("vec%0d", i), tbl[i].e_vld, tbl[i].e_ins, tbl[i].e_upd,
                 tbl[i].e_mpc, tbl[i].e_rdy);
    end

    // rdy_in low during MISS: upd pulse is dropped, nothing moves.
    drive(1, 1, 0, 1, 32'h200, 0, '0, 4'h0, 24'h0);
    step();
    expect_out("frz_miss", 0, 32'hE000_0001, 1, 32'h200, 0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 0, 32'h0, (k == 2), blk_f, 4'h0, 24'h2);
      step();
      expect_out($sformatf("frz%0d", k), 0, 32'hE000_0001, 1, 32'h200, 0);
    end
    drive(1, 1, 0, 0, 32'h0, 0, '0, 4'h0, 24'h0);
    step();
    expect_out("frz_after", 0, 32'hE000_0001, 1, 32'h200, 0);
    drive(1, 1, 0, 0, 32'h0, 1, blk_f, 4'h0, 24'h2);
    step();
    expect_out("frz_refill", 1, 32'hF000_0000, 0, 32'h200, 1);
    drive(1, 1, 0, 1, 32'h204, 0, '0, 4'h0, 24'h0);
    step();
    expect_out("pre_rst_hit", 1, 32'hF000_0001, 0, 32'h200, 1);

    // Reset during MISS aborts the request and clears every valid bit.
    drive(1, 1, 0, 1, 32'h30, 0, '0, 4'h0, 24'h0);
    step();
    expect_out("rst_miss", 0, 32'hF000_0001, 1, 32'h30, 0);
    drive(0, 0, 0, 0, 32'h0, 0, '0, 4'h0, 24'h0);
    step();
    expect_out("rst_abort", 0, 32'h0, 0, 32'h0, 1);
    drive(1, 1, 0, 1, 32'h204, 0, '0, 4'h0, 24'h0);
    step();
    expect_out("rst_remiss", 0, 32'h0, 1, 32'h200, 0);
    drive(1, 1, 0, 0, 32'h0, 1, blk_f, 4'h0, 24'h2);
    step();
    expect_out("rst_refill", 1, 32'hF000_0001, 0, 32'h200, 1);
`ifdef ICACHE_STAT_EN
    chk("hit_cnt", hit_cnt, 32'd0);
    chk("miss_cnt", miss_cnt, 32'd1);
`endif

    drive(1, 1, 0, 0, 32'h0, 0, '0, 4'h0, 24'h0);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
